// File: rtl/writeback_stage.sv
// MEM/WB stage of the RV32I core: registers one retiring instruction per cycle,
// formats its result (ALU, extended load, link) and counts retired instructions.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd_addr,
    input  logic [1:0]       in_wb_sel,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_load_data,
    input  logic [2:0]       in_load_funct3,
    input  logic [XLEN-1:0]  in_pc_plus4,
    output logic [4:0]       rd_addr,
    output logic [XLEN-1:0]  rd_data,
    output logic             reg_write,
    output logic             wb_valid,
    output logic             load_fault,
    output logic [CNT_W-1:0] instret
);
    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic             accept;
    logic [1:0]       addr_lo;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic             fault_next;
    logic             write_next;
    logic [XLEN-1:0]  data_next;

    logic             wb_valid_reg;
    logic             reg_write_reg;
    logic             load_fault_reg;
    logic [4:0]       rd_addr_reg;
    logic [XLEN-1:0]  rd_data_reg;
    logic [CNT_W-1:0] instret_reg;

    assign in_ready  = ~stall;
    assign accept    = in_valid & ~stall & ~flush;
    assign addr_lo   = in_alu_result[1:0];
    assign load_byte = in_load_data[{addr_lo, 3'b000} +: 8];
    assign load_half = in_load_data[{addr_lo[1], 4'b0000} +: 16];

    // Result formatting happens ahead of the stage register so every output is registered.
    always_comb begin
        fault_next = 1'b0;
        data_next  = '0;
        case (in_wb_sel)
            SEL_ALU:  data_next = in_alu_result;
            SEL_LINK: data_next = in_pc_plus4;
            SEL_LOAD: begin
                case (in_load_funct3)
                    F3_LB:  data_next = {{(XLEN-8){load_byte[7]}}, load_byte};
                    F3_LBU: data_next = {{(XLEN-8){1'b0}}, load_byte};
                    F3_LH: begin
                        if (addr_lo[0]) fault_next = 1'b1;
                        else            data_next  = {{(XLEN-16){load_half[15]}}, load_half};
                    end
                    F3_LHU: begin
                        if (addr_lo[0]) fault_next = 1'b1;
                        else            data_next  = {{(XLEN-16){1'b0}}, load_half};
                    end
                    F3_LW: begin
                        if (addr_lo != 2'b00) fault_next = 1'b1;
                        else                  data_next  = in_load_data;
                    end
                    default: fault_next = 1'b1;
                endcase
            end
            default: data_next = '0;
        endcase
    end

    // x0 writes and the reserved selector never reach the register file.
    assign write_next = in_reg_write & (in_rd_addr != 5'd0) & ~fault_next & (in_wb_sel != 2'b11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_reg   <= 1'b0;
            reg_write_reg  <= 1'b0;
            load_fault_reg <= 1'b0;
            rd_addr_reg    <= '0;
            rd_data_reg    <= '0;
            instret_reg    <= '0;
        end else begin
            wb_valid_reg   <= accept;
            reg_write_reg  <= accept & write_next;
            load_fault_reg <= accept & fault_next;
            if (accept) begin
                rd_addr_reg <= in_rd_addr;
                rd_data_reg <= data_next;
            end
            if (wb_valid_reg && !load_fault_reg)
                instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    assign wb_valid   = wb_valid_reg;
    assign reg_write  = reg_write_reg;
    assign load_fault = load_fault_reg;
    assign rd_addr    = rd_addr_reg;
    assign rd_data    = rd_data_reg;
    assign instret    = instret_reg;
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed test-plan cases followed by
// random traffic, checked against a behavioural model of the retire rules.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, stall, flush, in_reg_write;
    logic [4:0]  in_rd_addr;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result, in_load_data, in_pc_plus4;
    logic [2:0]  in_load_funct3;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write, wb_valid, load_fault;
    logic [63:0] instret;

    typedef struct {
        bit          valid;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          we;
        bit          fault;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    logic [63:0] exp_instret = '0;

    writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .in_reg_write(in_reg_write),
        .in_rd_addr(in_rd_addr), .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
        .in_load_data(in_load_data), .in_load_funct3(in_load_funct3),
        .in_pc_plus4(in_pc_plus4), .rd_addr(rd_addr), .rd_data(rd_data),
        .reg_write(reg_write), .wb_valid(wb_valid), .load_fault(load_fault),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Retire rules stated directly: shift the word to the addressed lane, then extend.
    function automatic void model(input logic [1:0] sel, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] ld,
                                  input logic [31:0] alu, input logic [31:0] pc,
                                  output bit flt, output logic [31:0] res);
        int a, b, h;
        a = int'(addr % 4);
        b = int'((ld >> (8 * a)) & 32'hFF);
        h = int'((ld >> (16 * (a / 2))) & 32'hFFFF);
        flt = 1'b0;
        res = 32'd0;
        if (sel == 2'd0) res = alu;
        else if (sel == 2'd2) res = pc;
        else if (sel == 2'd1) begin
            case (f3)
                3'd0: res = (b >= 128) ? 32'(b - 256) : 32'(b);
                3'd4: res = 32'(b);
                3'd1: if (a % 2 != 0) flt = 1'b1; else res = (h >= 32768) ? 32'(h - 65536) : 32'(h);
                3'd5: if (a % 2 != 0) flt = 1'b1; else res = 32'(h);
                3'd2: if (a != 0) flt = 1'b1; else res = ld;
                default: flt = 1'b1;
            endcase
        end
        if (flt) res = 32'd0;
    endfunction

    task automatic drive(input bit v, input bit st, input bit fl, input bit we,
                         input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [2:0] f3, input logic [31:0] pc);
        exp_t e;
        bit flt;
        logic [31:0] res;
        in_valid = v; stall = st; flush = fl; in_reg_write = we; in_rd_addr = rd;
        in_wb_sel = sel; in_alu_result = alu; in_load_data = ld;
        in_load_funct3 = f3; in_pc_plus4 = pc;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, ~st});
        model(sel, f3, alu, ld, alu, pc, flt, res);
        e.valid = v && !st && !fl;
        e.rd    = rd;
        e.data  = res;
        e.fault = e.valid && flt;
        e.we    = e.valid && we && (rd != 5'd0) && !flt && (sel != 2'd3);
        @(posedge clk);
        sb_q.push_back(e);
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("wb_valid", {63'd0, wb_valid}, {63'd0, e.valid});
            chk("instret", instret, exp_instret);
            if (e.valid) begin
                chk("rd_addr", {59'd0, rd_addr}, {59'd0, e.rd});
                chk("rd_data", {32'd0, rd_data}, {32'd0, e.data});
                chk("reg_write", {63'd0, reg_write}, {63'd0, e.we});
                chk("load_fault", {63'd0, load_fault}, {63'd0, e.fault});
                $display("retire rd=%0d data=%h we=%0b fault=%0b instret=%0d",
                         rd_addr, rd_data, reg_write, load_fault, instret);
                if (!e.fault) exp_instret = exp_instret + 64'd1;
            end else begin
                chk("bubble_reg_write", {63'd0, reg_write}, 64'd0);
                chk("bubble_load_fault", {63'd0, load_fault}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ld;
        reset = 1'b0;
        in_valid = 0; stall = 0; flush = 0; in_reg_write = 0; in_rd_addr = 0;
        in_wb_sel = 0; in_alu_result = 0; in_load_data = 0; in_load_funct3 = 0; in_pc_plus4 = 0;
        #12;
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
        chk("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        chk("rst_load_fault", {63'd0, load_fault}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        #8 reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #2;

        drive(1, 0, 0, 1, 5'd1, 2'd0, 32'hDEADBEEF, 32'd0, 3'd0, 32'd0);
        ld = 32'h8765F0A1;
        drive(1, 0, 0, 1, 5'd2, 2'd1, 32'h00000100, ld, 3'b000, 32'd0);
        drive(1, 0, 0, 1, 5'd3, 2'd1, 32'h00000101, ld, 3'b100, 32'd0);
        drive(1, 0, 0, 1, 5'd4, 2'd1, 32'h00000102, ld, 3'b001, 32'd0);
        drive(1, 0, 0, 1, 5'd5, 2'd1, 32'h00000100, ld, 3'b101, 32'd0);
        drive(1, 0, 0, 1, 5'd6, 2'd1, 32'h00000100, ld, 3'b010, 32'd0);
        drive(1, 0, 0, 1, 5'd7, 2'd1, 32'h00000101, ld, 3'b001, 32'd0);
        drive(1, 0, 0, 1, 5'd8, 2'd1, 32'h00000102, ld, 3'b010, 32'd0);
        drive(1, 0, 0, 1, 5'd9, 2'd1, 32'h00000100, ld, 3'b011, 32'd0);
        drive(1, 0, 0, 1, 5'd0, 2'd0, 32'hFFFFFFFF, 32'd0, 3'd0, 32'd0);
        drive(1, 0, 0, 1, 5'd5, 2'd2, 32'd0, 32'd0, 3'd0, 32'h00000104);
        drive(1, 0, 0, 1, 5'd10, 2'd3, 32'h12345678, 32'd0, 3'd0, 32'd0);
        drive(1, 1, 0, 1, 5'd11, 2'd0, 32'h11111111, 32'd0, 3'd0, 32'd0);
        drive(1, 0, 1, 1, 5'd12, 2'd0, 32'h22222222, 32'd0, 3'd0, 32'd0);
        drive(1, 1, 1, 1, 5'd13, 2'd0, 32'h33333333, 32'd0, 3'd0, 32'd0);
        for (int i = 0; i < 4; i++)
            drive(1, 0, 0, 1, 5'(20 + i), 2'd0, 32'(i * 7 + 1), 32'd0, 3'd0, 32'd0);
        idle();

        // Asynchronous reset landing between edges while an entry is retiring.
        drive(1, 0, 0, 1, 5'd14, 2'd0, 32'hCAFEF00D, 32'd0, 3'd0, 32'd0);
        mon_en = 1'b0;
        chk("pre_reset_wb_valid", {63'd0, wb_valid}, 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("async_reg_write", {63'd0, reg_write}, 64'd0);
        chk("async_instret", instret, 64'd0);
        sb_q.delete();
        exp_instret = '0;
        in_valid = 0;
        @(posedge clk); #3;
        reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0,
                  5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom);
        end
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (MEM/WB) pipeline stage of the RV32I core, directly upstream of register_file.
- Latches one retiring instruction per cycle from the memory stage.
- Selects and formats the result (ALU, aligned and sign/zero-extended load, PC+4).
- Drives rd_addr/rd_data/reg_write into register_file and counts retired instructions.

Parameters:
XLEN, 32, datapath width
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  core clock
reset  in  1  one clock; reset is asynchronous and active-low
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  stage accepts this cycle (= ~stall)
stall  in  1  hazard unit blocks acceptance
flush  in  1  kill the instruction currently offered
in_reg_write  in  1  instruction writes rd
in_rd_addr  in  5  destination register
in_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
in_alu_result  in  XLEN  ALU result; for loads, the effective address
in_load_data  in  XLEN  raw aligned word from data memory
in_load_funct3  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
in_pc_plus4  in  XLEN  link value
rd_addr  out  5  to register_file
rd_data  out  XLEN  to register_file and forwarding network
reg_write  out  1  to register_file
wb_valid  out  1  stage holds a retiring instruction
load_fault  out  1  one-cycle pulse: misaligned or illegal load retired
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, asynchronous): wb_valid=0, reg_write=0, rd_addr=0, rd_data=0, load_fault=0, instret=0. The stage register clears immediately, independent of clk.
- Acceptance: accept = in_valid & ~stall & ~flush, sampled on the rising clk edge.
- in_ready = ~stall, combinational. flush does not affect in_ready.
- Latency: exactly 1 cycle. An instruction accepted at edge N drives outputs from edge N until edge N+1.
- WB never holds an entry. If nothing is accepted at an edge, wb_valid=0 and reg_write=0 for the following cycle.
- flush kills only the offered instruction. An already-latched entry still retires. flush with stall gives a bubble.
- Result formatting is computed before the register, so all outputs are registered.
  - sel 00: rd_data = in_alu_result.
  - sel 10: rd_data = in_pc_plus4.
  - sel 11: no write (reg_write=0), rd_data=0; counted as retired.
  - sel 01: a = in_alu_result[1:0].
    - lb/lbu: byte in_load_data[8a+7:8a], sign-/zero-extended.
    - lh/lhu: half at bit 16*a[1], sign-/zero-extended. Requires a[0]=0.
    - lw: requires a=00.
- Load fault: a misaligned load, or a funct3 outside {000,001,010,100,101}, is a fault.
  - load_fault=1 and reg_write=0 for that cycle; rd_data=0.
  - The instruction is not counted in instret.
- reg_write = wb_valid & in_reg_write(latched) & (rd_addr != 0) & ~fault. x0 writes are suppressed here as well as in register_file.
- rd_addr is latched even when the write is suppressed.
- instret increments by 1 on each edge where wb_valid=1 and load_fault=0. It wraps from 2^CNT_W-1 to 0 silently.
- Outputs are undriven by stale data: when wb_valid=0, reg_write=0 and load_fault=0. rd_addr/rd_data may hold their last values.
- Reset asserted mid-stream: the pending entry is discarded (no write), and instret clears.

Test Plan:
- Reset then ALU write: reset low 20 ns then high; offer sel=00, rd=1, alu=DEADBEEF, reg_write=1 -> next cycle rd_addr=1, rd_data=DEADBEEF, reg_write=1, wb_valid=1; instret=1 after the following edge; register_file x1 reads DEADBEEF.
- Load formatting: load_data=8765F0A1.
  - lb, addr ...0 -> rd_data=FFFFFFA1.
  - lbu, addr ...1 -> 000000F0.
  - lh, addr ...2 -> FFFF8765.
  - lhu, addr ...0 -> 0000F0A1.
  - lw, addr ...0 -> 8765F0A1.
- Faults: lh at addr ...1 -> load_fault=1, reg_write=0, instret unchanged. lw at addr ...2 -> same. funct3=011 -> same.
- x0 and link: rd=0, sel=00, alu=FFFFFFFF -> reg_write=0, instret increments; x0 still reads 0. sel=10, rd=5, pc_plus4=00000104 -> rd_data=00000104.
- Stall/flush:
  - in_valid=1 with stall=1 -> in_ready=0; wb_valid=0 next cycle; instret unchanged.
  - flush=1 -> in_ready=1 but wb_valid=0 next cycle.
  - Back-to-back accepts for 4 cycles -> instret +4.
- Async reset mid-operation: drive reset=0 between clk edges while wb_valid=1 -> reg_write, wb_valid, and instret go 0 immediately, without a clk edge.
